io_port_bank: RTL and testbench

//  Responder on the MMU I/O port (0x80000000-0x800000FF); decodes io_addr into a small register bank.

---
 rtl/io_port_bank_if.sv | 11 +
 rtl/io_port_bank.sv | 184 ++++++++++++++++++
 tb/tb_io_port_bank.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_bank_if.sv
// MMU I/O port bus: registered address/strobe/write data from the MMU, combinational read data back.
interface io_port_bank_if;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;

  modport master (output io_addr, io_en, io_we, io_data_write, input io_data_read);
  modport slave  (input io_addr, io_en, io_we, io_data_write, output io_data_read);
endinterface

// File: rtl/io_port_bank.sv
// I/O register bank on the MMU port: LED register, synchronized switches, cycle counter
// and a FIFO-fed 8N1 UART transmitter.
module io_port_bank #(
  parameter int unsigned CLKS_PER_BIT   = 104,
  parameter int unsigned FIFO_DEPTH_LOG = 3
) (
  input  logic            clk,
  input  logic            resetb,
  io_port_bank_if.slave   io,
  input  logic [7:0]      sw,
  output logic [7:0]      led,
  output logic            uart_tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG;
  localparam int unsigned FCNT_W = FIFO_DEPTH_LOG + 1;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG;

  localparam logic [5:0] A_LED  = 6'h00;
  localparam logic [5:0] A_SW   = 6'h01;
  localparam logic [5:0] A_TXD  = 6'h02;
  localparam logic [5:0] A_STAT = 6'h03;
  localparam logic [5:0] A_CYC  = 6'h04;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  logic [5:0]        word;
  logic              wr, wr_led, wr_txd, wr_stat, wr_cyc;
  logic              unused_addr_bits;

  logic [7:0]        sw_meta, sw_sync;
  logic [31:0]       cyc;

  logic [7:0]        fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              full, empty, push, pop, overflow;
  logic [7:0]        head;

  tx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              tx_nxt, bit_last, busy;

  assign word             = io.io_addr[7:2];
  assign unused_addr_bits = ^io.io_addr[1:0];
  assign wr      = io.io_en & io.io_we;
  assign wr_led  = wr && (word == A_LED);
  assign wr_txd  = wr && (word == A_TXD);
  assign wr_stat = wr && (word == A_STAT);
  assign wr_cyc  = wr && (word == A_CYC);

  assign full  = (fifo_cnt == FCNT_W'(DEPTH));
  assign empty = (fifo_cnt == '0);
  assign push  = wr_txd & ~full;
  assign head  = fifo_mem[rd_ptr];
  assign busy  = (state != S_IDLE);

  // LED register, switch synchronizer and cycle counter (a write beats the increment)
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      led     <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      cyc     <= '0;
    end else begin
      if (wr_led) led <= io.io_data_write[7:0];
      sw_meta <= sw;
      sw_sync <= sw_meta;
      cyc     <= wr_cyc ? io.io_data_write : cyc + 32'd1;
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= io.io_data_write[7:0];
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (wr_txd && full)                        overflow <= 1'b1;
      else if (wr_stat && io.io_data_write[3])   overflow <= 1'b0;
    end
  end

  // TX FSM state and datapath registers; uart_tx comes straight from a flop
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      uart_tx <= tx_nxt;
    end
  end

  assign bit_last = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // TX next-state; the line level is decoded from the next state so it changes with the state
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    tx_nxt      = 1'b1;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          shift_nxt   = head;
          bit_cnt_nxt = '0;
          state_nxt   = S_START;
        end
      end
      S_START: begin
        if (bit_last) begin
          bit_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_DATA;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_last) begin
          bit_cnt_nxt = '0;
          shift_nxt   = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nxt = S_STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_last) begin
          bit_cnt_nxt = '0;
          state_nxt   = S_IDLE;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // Combinational read mux; the MMU samples it in the access cycle
  always_comb begin
    io.io_data_read = '0;
    case (word)
      A_LED:  io.io_data_read = {24'h0, led};
      A_SW:   io.io_data_read = {24'h0, sw_sync};
      A_STAT: io.io_data_read = {16'h0, 8'(fifo_cnt), 4'h0, overflow, busy, empty, full};
      A_CYC:  io.io_data_read = cyc;
      default: io.io_data_read = '0;
    endcase
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank with a 4-clock UART bit time.
module tb_io_port_bank;
  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB + 1;

  logic       clk = 1'b0;
  logic       resetb;
  logic [7:0] sw;
  logic [7:0] led;
  logic       uart_tx;

  io_port_bank_if bus();

  io_port_bank #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG(3)) dut (
    .clk(clk), .resetb(resetb), .io(bus), .sw(sw), .led(led), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int unsigned tb_cyc = 0;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Single-cycle write; call at a negedge, returns at the next negedge
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus.io_addr = a; bus.io_data_write = d; bus.io_en = 1'b1; bus.io_we = 1'b1;
    @(negedge clk);
    bus.io_en = 1'b0; bus.io_we = 1'b0;
  endtask

  // Read within the current low phase
  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus.io_addr = a; bus.io_we = 1'b0; bus.io_en = 1'b1;
    #1;
    d = bus.io_data_read;
    bus.io_en = 1'b0;
  endtask

  // Line monitor: finds a start bit, samples mid-bit, reports start cycle
  task automatic rx_byte(output logic [7:0] b, output logic stop_bit,
                         output int unsigned t0, output bit tmo);
    int n = 0;
    b = '0; stop_bit = 1'b0; t0 = 0; tmo = 1'b0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tmo = 1'b1;
      return;
    end
    t0 = tb_cyc;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      b[k] = uart_tx;
      repeat (4) @(negedge clk);
    end
    stop_bit = uart_tx;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    resetb = 1'b1; sw = 8'hFF;
    bus.io_en = 1'b0; bus.io_we = 1'b0; bus.io_addr = '0; bus.io_data_write = '0;
    #2 resetb = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h want 00", led); end
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    bus_read(8'h04, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_sw_sync: got %h want 0", rd); end
    @(negedge clk);
    resetb = 1'b1;
    bus_read(8'h0C, rd);
    n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL reset_stat: got %h want 2", rd); end
    bus_read(8'h10, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_cyc0: got %h want 0", rd); end
    repeat (3) @(negedge clk);
    bus_read(8'h10, rd);
    n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL reset_cyc3: got %h want 3", rd); end
  endtask

  task automatic test_led_sw;
    logic [31:0] rd;
    @(negedge clk);
    bus_write(8'h00, 32'h1A5);
    n_checks++; if (led !== 8'hA5) begin n_fail++; $display("FAIL led_pin: got %h want a5", led); end
    bus_read(8'h00, rd);
    n_checks++; if (rd !== 32'hA5) begin n_fail++; $display("FAIL led_read: got %h want a5", rd); end
    bus_read(8'h03, rd);
    n_checks++; if (rd !== 32'hA5) begin n_fail++; $display("FAIL led_bytealias: got %h want a5", rd); end
    @(negedge clk);
    sw = 8'h3C;
    bus_read(8'h04, rd);
    n_checks++; if (rd !== 32'hFF) begin n_fail++; $display("FAIL sw_lat0: got %h want ff", rd); end
    @(negedge clk);
    bus_read(8'h04, rd);
    n_checks++; if (rd !== 32'hFF) begin n_fail++; $display("FAIL sw_lat1: got %h want ff", rd); end
    @(negedge clk);
    bus_read(8'h04, rd);
    n_checks++; if (rd !== 32'h3C) begin n_fail++; $display("FAIL sw_lat2: got %h want 3c", rd); end
    @(negedge clk);
    bus_write(8'h04, 32'hFFFF_FFFF);
    bus_write(8'h20, 32'h0000_0011);
    n_checks++; if (led !== 8'hA5) begin n_fail++; $display("FAIL ignored_writes_led: got %h want a5", led); end
    bus_read(8'h20, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", rd); end
    bus_read(8'h08, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL txd_read: got %h want 0", rd); end
  endtask

  task automatic test_uart;
    logic [31:0] rd;
    logic [7:0]  byte_v;
    logic        exp_bit;
    int          slot;
    byte_v = 8'h55;
    @(negedge clk);
    bus_write(8'h08, {24'h0, byte_v});
    bus_read(8'h0C, rd);
    n_checks++; if (rd !== 32'h100) begin n_fail++; $display("FAIL uart_queued_stat: got %h want 100", rd); end
    for (int i = 0; i < 10 * int'(CPB); i++) begin
      @(negedge clk);
      slot = i / int'(CPB);
      if (slot == 0)      exp_bit = 1'b0;
      else if (slot == 9) exp_bit = 1'b1;
      else                exp_bit = byte_v[slot-1];
      n_checks++; if (uart_tx !== exp_bit) begin n_fail++; $display("FAIL uart_line[%0d]: got %b want %b", i, uart_tx, exp_bit); end
      bus_read(8'h0C, rd);
      n_checks++; if (rd[2] !== 1'b1) begin n_fail++; $display("FAIL uart_busy[%0d]: got %b want 1", i, rd[2]); end
    end
    @(negedge clk);
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL uart_idle_tx: got %b want 1", uart_tx); end
    bus_read(8'h0C, rd);
    n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL uart_idle_stat: got %h want 2", rd); end
  endtask

  task automatic test_fifo;
    logic [7:0]  got  [9];
    logic        stp  [9];
    int unsigned t0s  [9];
    bit          tmo  [9];
    logic [31:0] rd;
    logic [7:0]  exp_b;
    bit          line_quiet;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 9; k++) rx_byte(got[k], stp[k], t0s[k], tmo[k]);
      end
      begin
        for (int k = 0; k < 9; k++) bus_write(8'h08, 32'h31 + 32'(k));
        bus_read(8'h0C, rd);
        n_checks++; if (rd !== 32'h0805) begin n_fail++; $display("FAIL fifo_full_stat: got %h want 805", rd); end
        bus_write(8'h08, 32'hAA);
        bus_read(8'h0C, rd);
        n_checks++; if (rd !== 32'h080D) begin n_fail++; $display("FAIL fifo_ovf_stat: got %h want 80d", rd); end
        bus_write(8'h0C, 32'h8);
        bus_read(8'h0C, rd);
        n_checks++; if (rd !== 32'h0805) begin n_fail++; $display("FAIL fifo_ovf_clear: got %h want 805", rd); end
      end
    join
    for (int k = 0; k < 9; k++) begin
      exp_b = 8'h31 + 8'(k);
      n_checks++; if (tmo[k] !== 1'b0) begin n_fail++; $display("FAIL fifo_rx_timeout[%0d]: got %b want 0", k, tmo[k]); end
      n_checks++; if (got[k] !== exp_b) begin n_fail++; $display("FAIL fifo_rx_byte[%0d]: got %h want %h", k, got[k], exp_b); end
      n_checks++; if (stp[k] !== 1'b1) begin n_fail++; $display("FAIL fifo_rx_stop[%0d]: got %b want 1", k, stp[k]); end
      if (k > 0) begin
        n_checks++; if (t0s[k] - t0s[k-1] !== FRAME) begin n_fail++; $display("FAIL fifo_gap[%0d]: got %0d want %0d", k, t0s[k] - t0s[k-1], FRAME); end
      end
    end
    line_quiet = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) line_quiet = 1'b0;
    end
    n_checks++; if (line_quiet !== 1'b1) begin n_fail++; $display("FAIL fifo_dropped_byte_sent: got %b want 1", line_quiet); end
    bus_read(8'h0C, rd);
    n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL fifo_drained_stat: got %h want 2", rd); end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  got [2];
    logic        stp [2];
    int unsigned t0s [2];
    bit          tmo [2];
    logic [31:0] rd;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 2; k++) rx_byte(got[k], stp[k], t0s[k], tmo[k]);
      end
      begin
        bus_write(8'h08, 32'h11);
        bus_read(8'h0C, rd);
        n_checks++; if (rd !== 32'h0100) begin n_fail++; $display("FAIL b2b_before_pop: got %h want 100", rd); end
        bus_write(8'h08, 32'h22);
        bus_read(8'h0C, rd);
        n_checks++; if (rd !== 32'h0104) begin n_fail++; $display("FAIL b2b_push_pop_count: got %h want 104", rd); end
      end
    join
    n_checks++; if (tmo[0] !== 1'b0 || tmo[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %b%b want 00", tmo[0], tmo[1]); end
    n_checks++; if (got[0] !== 8'h11) begin n_fail++; $display("FAIL b2b_first: got %h want 11", got[0]); end
    n_checks++; if (got[1] !== 8'h22) begin n_fail++; $display("FAIL b2b_second: got %h want 22", got[1]); end
    n_checks++; if (t0s[1] - t0s[0] !== FRAME) begin n_fail++; $display("FAIL b2b_gap: got %0d want %0d", t0s[1] - t0s[0], FRAME); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_cyc;
    logic [31:0] rd;
    @(negedge clk);
    bus_write(8'h10, 32'hFFFF_FFFE);
    bus_read(8'h10, rd);
    n_checks++; if (rd !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cyc_loaded: got %h want fffffffe", rd); end
    @(negedge clk);
    bus_read(8'h10, rd);
    n_checks++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cyc_plus1: got %h want ffffffff", rd); end
    @(negedge clk);
    bus_read(8'h10, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL cyc_wrap: got %h want 0", rd); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] rd;
    bit          line_quiet;
    @(negedge clk);
    bus_write(8'h08, 32'h0F);
    bus_write(8'h08, 32'hF0);
    n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL midrst_start_bit: got %b want 0", uart_tx); end
    #2 resetb = 1'b0;
    #1;
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL midrst_async_tx: got %b want 1", uart_tx); end
    n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL midrst_led: got %h want 00", led); end
    bus_read(8'h0C, rd);
    n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL midrst_stat: got %h want 2", rd); end
    @(negedge clk);
    resetb = 1'b1;
    line_quiet = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) line_quiet = 1'b0;
    end
    n_checks++; if (line_quiet !== 1'b1) begin n_fail++; $display("FAIL midrst_fifo_lost: got %b want 1", line_quiet); end
    bus_read(8'h0C, rd);
    n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL midrst_stat_after: got %h want 2", rd); end
  endtask

  initial begin
    test_reset;
    test_led_sw;
    test_uart;
    test_fifo;
    test_back_to_back;
    test_cyc;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
